// File: rtl/core_pkg.sv
// Shared types and constants for the core's program-counter stage.
package core_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TRAP = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: branch/jal/jalr targets, priority mux and
// misaligned-target fault detection.
module pc_target_calc
    import core_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [Width-1:0] pc,
    input  logic [Width-1:0] offset_i,
    input  logic [Width-1:0] rs1_i,
    input  logic [Width-1:0] jalr_imm_i,
    input  logic             branch_taken_i,
    input  logic             jal_i,
    input  logic             jalr_i,
    output logic [Width-1:0] next_pc,
    output logic             fault
);

    logic [Width-1:0] br_tgt;
    logic [Width-1:0] jr_tgt;

    always_comb begin
        br_tgt  = pc + offset_i;
        jr_tgt  = (rs1_i + jalr_imm_i) & ~Width'(1);
        next_pc = pc + Width'(PC_STEP);
        fault   = 1'b0;
        // Only redirected targets can be misaligned; sequential PC stays 4-aligned.
        if (jalr_i) begin
            next_pc = jr_tgt;
            fault   = jr_tgt[1];
        end else if (jal_i || branch_taken_i) begin
            next_pc = br_tgt;
            fault   = br_tgt[1];
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// PC register, trap/halt FSM and retired-instruction counter. stall_i acts as
// a not-ready: when high, no instruction executes and no state moves.
module pc_next_unit
    import core_pkg::*;
#(
    parameter int               Width    = 32,
    parameter logic [Width-1:0] RESET_PC = Width'(DEFAULT_RESET_PC),
    parameter logic [Width-1:0] TRAP_PC  = Width'(DEFAULT_TRAP_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic             jal_i,
    input  logic             jalr_i,
    input  logic [Width-1:0] offset_i,
    input  logic [Width-1:0] rs1_i,
    input  logic [Width-1:0] jalr_imm_i,
    input  logic             trap_clr_i,
    output logic [Width-1:0] pc_o,
    output logic [Width-1:0] pc_plus4_o,
    output logic [Width-1:0] epc_o,
    output logic             trap_o,
    output logic             halted_o,
    output logic [Width-1:0] retire_cnt_o,
    output pc_state_t        state_o
);

    pc_state_t        state_q, state_n;
    logic [Width-1:0] pc_q, pc_n;
    logic [Width-1:0] epc_q, epc_n;
    logic [Width-1:0] cnt_q, cnt_n;
    logic             trap_q, trap_n;
    logic             halted_q, halted_n;
    logic [Width-1:0] next_pc;
    logic             fault;

    pc_target_calc #(.Width(Width)) u_calc (
        .pc             (pc_q),
        .offset_i       (offset_i),
        .rs1_i          (rs1_i),
        .jalr_imm_i     (jalr_imm_i),
        .branch_taken_i (branch_taken_i),
        .jal_i          (jal_i),
        .jalr_i         (jalr_i),
        .next_pc        (next_pc),
        .fault          (fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            epc_q    <= '0;
            cnt_q    <= '0;
            trap_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            pc_q     <= pc_n;
            epc_q    <= epc_n;
            cnt_q    <= cnt_n;
            trap_q   <= trap_n;
            halted_q <= halted_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        epc_n    = epc_q;
        cnt_n    = cnt_q;
        trap_n   = trap_q;
        halted_n = halted_q;
        if (!stall_i) begin
            case (state_q)
                RUN: begin
                    if (fault) begin
                        pc_n    = TRAP_PC;
                        epc_n   = pc_q;
                        trap_n  = 1'b1;
                        state_n = TRAP;
                    end else begin
                        pc_n  = next_pc;
                        cnt_n = cnt_q + Width'(1);
                    end
                end
                TRAP: begin
                    // A second fault beats a same-cycle acknowledge.
                    if (fault) begin
                        halted_n = 1'b1;
                        state_n  = HALT;
                    end else begin
                        pc_n  = next_pc;
                        cnt_n = cnt_q + Width'(1);
                        if (trap_clr_i) begin
                            trap_n  = 1'b0;
                            state_n = RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc_q + Width'(PC_STEP);
    assign epc_o        = epc_q;
    assign trap_o       = trap_q;
    assign halted_o     = halted_q;
    assign retire_cnt_o = cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit; a narrow second instance covers counter wrap.
module tb_pc_next_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, branch_taken_i, jal_i, jalr_i, trap_clr_i;
    logic [31:0] offset_i, rs1_i, jalr_imm_i;
    logic [31:0] pc_o, pc_plus4_o, epc_o, retire_cnt_o;
    logic        trap_o, halted_o;
    pc_state_t   state_o;

    logic       s_zero = 1'b0;
    logic [7:0] s_zero8 = 8'h00;
    logic [7:0] s_pc, s_pc4, s_epc, s_cnt;
    logic       s_trap, s_halted;
    pc_state_t  s_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_next_unit #(.Width(32)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
        .jal_i(jal_i), .jalr_i(jalr_i), .offset_i(offset_i), .rs1_i(rs1_i),
        .jalr_imm_i(jalr_imm_i), .trap_clr_i(trap_clr_i), .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o), .epc_o(epc_o), .trap_o(trap_o), .halted_o(halted_o),
        .retire_cnt_o(retire_cnt_o), .state_o(state_o)
    );

    pc_next_unit #(.Width(8), .RESET_PC(8'h00), .TRAP_PC(8'h40)) u_small (
        .clk(clk), .rst(rst), .stall_i(s_zero), .branch_taken_i(s_zero),
        .jal_i(s_zero), .jalr_i(s_zero), .offset_i(s_zero8), .rs1_i(s_zero8),
        .jalr_imm_i(s_zero8), .trap_clr_i(s_zero), .pc_o(s_pc),
        .pc_plus4_o(s_pc4), .epc_o(s_epc), .trap_o(s_trap), .halted_o(s_halted),
        .retire_cnt_o(s_cnt), .state_o(s_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; branch_taken_i = 0; jal_i = 0; jalr_i = 0; trap_clr_i = 0;
        offset_i = '0; rs1_i = '0; jalr_imm_i = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        // Reset state
        check("rst_pc", pc_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        check("rst_trap", 32'(trap_o), 32'h0);
        check("rst_halt", 32'(halted_o), 32'h0);
        check("rst_cnt", retire_cnt_o, 32'h0);
        check("rst_state", 32'(state_o), 32'(RUN));
        rst = 0;

        // 1: sequential
        tick(); check("seq_pc4", pc_o, 32'h4);
        tick(); check("seq_pc8", pc_o, 32'h8);
        tick(); check("seq_pc12", pc_o, 32'hC);
        check("seq_cnt", retire_cnt_o, 32'd3);
        check("seq_plus4", pc_plus4_o, 32'h10);

        // 2: jal to 0x20, backward branch, jalr with bit0 cleared, priority
        jal_i = 1; offset_i = 32'h14;
        tick(); check("jal_pc", pc_o, 32'h20);
        idle(); branch_taken_i = 1; offset_i = 32'hFFFF_FFF8;
        tick(); check("br_back_pc", pc_o, 32'h18);
        idle(); jalr_i = 1; rs1_i = 32'h101; jalr_imm_i = 32'h3;
        tick(); check("jalr_pc", pc_o, 32'h104);
        check("jalr_cnt", retire_cnt_o, 32'd6);
        idle(); jalr_i = 1; rs1_i = 32'h40; jal_i = 1; branch_taken_i = 1; offset_i = 32'h8;
        tick(); check("prio_pc", pc_o, 32'h40);

        // 3: misaligned jal traps, then acknowledge
        idle(); jal_i = 1; offset_i = 32'h6;
        tick();
        check("trap_pc", pc_o, 32'h100);
        check("trap_epc", epc_o, 32'h40);
        check("trap_flag", 32'(trap_o), 32'h1);
        check("trap_cnt", retire_cnt_o, 32'd7);
        check("trap_state", 32'(state_o), 32'(TRAP));
        idle(); trap_clr_i = 1;
        tick();
        check("clr_pc", pc_o, 32'h104);
        check("clr_flag", 32'(trap_o), 32'h0);
        check("clr_cnt", retire_cnt_o, 32'd8);
        check("clr_state", 32'(state_o), 32'(RUN));

        // 4: enter TRAP, step to 0x104, double fault with same-cycle clear
        idle(); jal_i = 1; offset_i = 32'h2;
        tick(); check("t2_pc", pc_o, 32'h100);
        check("t2_epc", epc_o, 32'h104);
        idle();
        tick(); check("t2_step_pc", pc_o, 32'h104);
        check("t2_step_trap", 32'(trap_o), 32'h1);
        idle(); branch_taken_i = 1; offset_i = 32'h2; trap_clr_i = 1;
        tick();
        check("df_halt", 32'(halted_o), 32'h1);
        check("df_pc", pc_o, 32'h104);
        check("df_epc", epc_o, 32'h104);
        check("df_cnt", retire_cnt_o, 32'd9);
        check("df_state", 32'(state_o), 32'(HALT));
        idle(); jalr_i = 1; rs1_i = 32'h200; trap_clr_i = 1;
        tick(); tick();
        check("halt_pc", pc_o, 32'h104);
        check("halt_cnt", retire_cnt_o, 32'd9);
        check("halt_flag", 32'(halted_o), 32'h1);
        idle(); rst = 1;
        tick(); rst = 0;
        check("hrst_pc", pc_o, 32'h0);
        check("hrst_halt", 32'(halted_o), 32'h0);
        check("hrst_trap", 32'(trap_o), 32'h0);
        check("hrst_state", 32'(state_o), 32'(RUN));

        // 5: stall holds a faulting jal, release takes the trap
        stall_i = 1; jal_i = 1; offset_i = 32'h6;
        for (int i = 0; i < 4; i++) tick();
        check("stall_pc", pc_o, 32'h0);
        check("stall_cnt", retire_cnt_o, 32'h0);
        check("stall_trap", 32'(trap_o), 32'h0);
        stall_i = 0;
        tick();
        check("unstall_pc", pc_o, 32'h100);
        check("unstall_trap", 32'(trap_o), 32'h1);
        check("unstall_epc", epc_o, 32'h0);
        idle(); stall_i = 1; trap_clr_i = 1;
        tick();
        check("stall_clr_trap", 32'(trap_o), 32'h1);
        check("stall_clr_pc", pc_o, 32'h100);
        stall_i = 0;
        tick();
        check("late_clr_pc", pc_o, 32'h104);
        check("late_clr_trap", 32'(trap_o), 32'h0);

        // 6: PC wrap at the top of the address space
        idle(); jalr_i = 1; rs1_i = 32'hFFFF_FFFC;
        tick(); check("top_pc", pc_o, 32'hFFFF_FFFC);
        check("top_plus4", pc_plus4_o, 32'h0);
        idle();
        tick(); check("wrap_pc", pc_o, 32'h0);

        // Counter wrap on the 8-bit instance
        rst = 1;
        tick(); rst = 0;
        check("s_rst_cnt", 32'(s_cnt), 32'h0);
        for (int i = 0; i < 255; i++) tick();
        check("s_cnt_max", 32'(s_cnt), 32'hFF);
        tick();
        check("s_cnt_wrap", 32'(s_cnt), 32'h0);
        check("s_pc_wrap", 32'(s_pc), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage of the single-cycle RISC core, directly downstream of the offset shifter (immediate << 1).
- Holds the PC register and computes the sequential, branch, jal and jalr next-PC values.
- Detects misaligned control-transfer targets and redirects to a trap vector.
- Tracks trap/halt state and counts retired instructions.

Parameters:
- Width, 32, datapath/PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- TRAP_PC, 32'h0000_0100, PC value loaded on a misaligned-target trap.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hold PC and all state this cycle.
- branch_taken_i  input  1  conditional branch resolved taken.
- jal_i  input  1  unconditional PC-relative jump.
- jalr_i  input  1  register-indirect jump.
- offset_i  input  Width  branch/jal offset, already shifted left by 1.
- rs1_i  input  Width  jalr base register value.
- jalr_imm_i  input  Width  sign-extended I-immediate for jalr, unshifted.
- trap_clr_i  input  1  software acknowledge that clears the trap state.
- pc_o  output  Width  current PC (register).
- pc_plus4_o  output  Width  pc_o + 4, combinational; link value.
- epc_o  output  Width  PC of the instruction that faulted (register).
- trap_o  output  1  trap pending, sticky.
- halted_o  output  1  core halted on double fault.
- retire_cnt_o  output  Width  retired-instruction counter.

Behaviour:
- Reset values (rst sampled high at the clock edge):
  - pc_o=RESET_PC, epc_o=0, trap_o=0, halted_o=0, retire_cnt_o=0, state=RUN.
  - rst has priority over every other input.
- Target arithmetic (modulo 2^Width, carries discarded):
  - br_tgt = pc_o + offset_i.
  - jr_tgt = (rs1_i + jalr_imm_i) with bit0 forced to 0.
- Selection priority when several requests are active: jalr_i > jal_i > branch_taken_i > sequential (pc_o+4).
- Misalignment: a selected br_tgt/jr_tgt with bit1 = 1 is a fault. No compressed ISA, so sequential PC never faults.
- FSM states RUN, TRAP, HALT; one transition per clock edge, registered.
- RUN:
  - If stall_i: nothing changes.
  - Else, no fault: pc_o <= selected next PC; retire_cnt_o += 1.
  - Else, fault: pc_o <= TRAP_PC; epc_o <= pc_o; trap_o <= 1; state -> TRAP; retire_cnt_o unchanged (faulting instruction does not retire).
- TRAP:
  - Executes normally from TRAP_PC with the same next-PC rules as RUN; trap_o stays 1.
  - trap_clr_i (not stalled) with no fault: trap_o <= 0, state -> RUN, and the instruction retires normally.
  - Fault while in TRAP (double fault): state -> HALT, halted_o <= 1, pc_o frozen at the faulting PC, epc_o unchanged.
  - Same-cycle fault and trap_clr_i: the fault wins, so state -> HALT.
- HALT:
  - pc_o, epc_o and retire_cnt_o are frozen.
  - All inputs except rst are ignored; only rst exits HALT.
- stall_i in any state freezes everything, including trap_clr_i and fault detection. A stalled instruction has not executed.
- retire_cnt_o wraps from 2^Width-1 to 0 without a flag.
- Latency: the next PC is visible on pc_o one cycle after the request. pc_plus4_o is combinational from pc_o.
- Reset in TRAP or HALT returns to RUN at RESET_PC in the same edge.

Decomposition:
- Shared package core_pkg:
  - typedef pc_state_t {RUN, TRAP, HALT}.
  - Constants PC_STEP=4, default RESET_PC and TRAP_PC.
- One sub-module: pc_target_calc, purely combinational. It produces br_tgt, jr_tgt, the selected next PC and the fault flag.
- The FSM, registers and counter stay in pc_next_unit.

Test Plan:
1. Reset then 3 unstalled cycles with no requests -> pc_o 0, 4, 8, 12; retire_cnt_o=3.
2. pc_o=0x20, branch_taken_i=1, offset_i=0xFFFF_FFF8 -> pc_o=0x18. Then jalr_i=1, rs1_i=0x101, jalr_imm_i=0x3 -> pc_o=0x104 (bit0 cleared).
3. pc_o=0x40, jal_i=1, offset_i=0x6 -> pc_o=TRAP_PC=0x100, epc_o=0x40, trap_o=1, retire_cnt_o unchanged. Next cycle trap_clr_i=1 -> pc_o=0x104, trap_o=0.
4. In TRAP at pc_o=0x104, branch_taken_i=1, offset_i=0x2, trap_clr_i=1 in the same cycle -> halted_o=1, pc_o stays 0x104. Further requests are ignored; rst -> pc_o=0, halted_o=0.
5. stall_i=1 held 4 cycles with jal_i=1, offset_i=0x6 (a misaligned target) -> pc_o, counter and trap_o unchanged. Release stall -> the trap is taken on that edge.
6. Preload retire_cnt_o near wrap via a long run (or a force): 0xFFFF_FFFF plus one retire -> 0. pc_o=0xFFFF_FFFC sequential -> 0x0000_0000.
